// File: rtl/per_rr_arbiter.sv
// Round-robin arbiter sharing one peripheral slave port among NB_MASTERS requesters.
// In-order responses are steered back to their issuer by a source-ID FIFO.
module per_rr_arbiter #(
    parameter int NB_MASTERS      = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NB_MASTERS-1:0]      m_req_i,
    input  logic [NB_MASTERS-1:0][31:0] m_add_i,
    input  logic [NB_MASTERS-1:0]      m_we_n_i,
    input  logic [NB_MASTERS-1:0][31:0] m_wdata_i,
    input  logic [NB_MASTERS-1:0][3:0] m_be_i,
    output logic [NB_MASTERS-1:0]      m_gnt_o,
    output logic [NB_MASTERS-1:0]      m_r_valid_o,
    output logic [NB_MASTERS-1:0]      m_r_opc_o,
    output logic [NB_MASTERS-1:0][31:0] m_r_rdata_o,
    output logic                       s_req_o,
    output logic [31:0]                s_add_o,
    output logic                       s_we_n_o,
    output logic [31:0]                s_wdata_o,
    output logic [3:0]                 s_be_o,
    input  logic                       s_gnt_i,
    input  logic                       s_r_valid_i,
    input  logic                       s_r_opc_i,
    input  logic [31:0]                s_r_rdata_i,
    output logic                       busy_o,
    output logic                       err_o
);

    // state     | meaning
    // ST_FREE   | winner chosen round-robin from rr_ptr
    // ST_LOCKED | previous request was not granted; lock_id keeps the slave port

    localparam int IW = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {ST_FREE, ST_LOCKED} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   lock_id_q, lock_id_d;
    logic [IW-1:0]   rr_ptr_q;
    logic [IW-1:0]   rr_win;
    logic [IW-1:0]   win;
    logic [IW-1:0]   scan_idx;
    logic            scan_found;
    logic            lock_hold;
    logic            any_req;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic [IW-1:0]   fifo_q [MAX_OUTSTANDING];
    logic [IW-1:0]   head;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            err_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(MAX_OUTSTANDING - 1)) return '0;
        return p + 1'b1;
    endfunction

    assign any_req   = |m_req_i;
    assign full      = (count_q == CW'(MAX_OUTSTANDING));
    assign empty     = (count_q == '0);
    assign lock_hold = (state_q == ST_LOCKED) && m_req_i[lock_id_q];
    assign win       = lock_hold ? lock_id_q : rr_win;
    assign s_req_o   = rst_ni & any_req & ~full;
    assign push      = s_req_o & s_gnt_i;
    assign pop       = s_r_valid_i & ~empty;
    assign head      = fifo_q[rd_ptr_q];

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        rr_win     = rr_ptr_q;
        scan_found = 1'b0;
        scan_idx   = '0;
        for (int i = 0; i < NB_MASTERS; i++) begin
            scan_idx = IW'((int'(rr_ptr_q) + i) % NB_MASTERS);
            if (!scan_found && m_req_i[scan_idx]) begin
                scan_found = 1'b1;
                rr_win     = scan_idx;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_FREE;
            lock_id_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
        end
    end

    // A dropped lock request simply falls back to round-robin via lock_hold.
    always_comb begin
        state_d   = ST_FREE;
        lock_id_d = lock_id_q;
        if (s_req_o && !s_gnt_i) begin
            state_d   = ST_LOCKED;
            lock_id_d = win;
        end
    end

    always_comb begin
        m_gnt_o     = '0;
        m_r_valid_o = '0;
        m_r_opc_o   = '0;
        if (push) m_gnt_o[win] = 1'b1;
        if (pop && rst_ni) begin
            m_r_valid_o[head] = 1'b1;
            m_r_opc_o[head]   = s_r_opc_i;
        end
        for (int i = 0; i < NB_MASTERS; i++) begin
            m_r_rdata_o[i] = rst_ni ? s_r_rdata_i : 32'h0;
        end
        s_add_o   = s_req_o ? m_add_i[win]   : 32'h0;
        s_we_n_o  = s_req_o ? m_we_n_i[win]  : 1'b0;
        s_wdata_o = s_req_o ? m_wdata_i[win] : 32'h0;
        s_be_o    = s_req_o ? m_be_i[win]    : 4'h0;
        busy_o    = ~empty;
        err_o     = err_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else if (push) begin
            rr_ptr_q <= (win == IW'(NB_MASTERS - 1)) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= win;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (s_r_valid_i && empty) begin
            err_q <= 1'b1;
        end
    end

endmodule
